// File: rtl/ysyx_24100006_lsu_pkg.sv
// LSU shared types: FSM states, funct3 sizes, AXI response codes.
// Imported by the LSU top and its alignment helper.
package ysyx_24100006_lsu_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ADDR,
    S_RD_DATA,
    S_WR_REQ,
    S_WR_RESP,
    S_DONE
  } lsu_state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [1:0] AXI_OKAY   = 2'b00;
  localparam logic [1:0] AXI_SLVERR = 2'b10;

  // Unsigned variants exist for loads only.
  function automatic logic size_legal(
    input logic [2:0] size,
    input logic       wen
  );
    logic ok;
    ok = 1'b0;
    unique case (size)
      F3_LB, F3_LH, F3_LW: ok = 1'b1;
      F3_LBU, F3_LHU:      ok = !wen;
      default:             ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/ysyx_24100006_lsu_align.sv
// LSU byte-lane alignment: store shift/strobe, load extract/extend,
// and the local reject check for misaligned or illegal accesses.
module ysyx_24100006_lsu_align
  import ysyx_24100006_lsu_pkg::*;
(
  input  logic [1:0]  off_i,
  input  logic [2:0]  size_i,
  input  logic        wen_i,
  input  logic [31:0] st_data_i,
  input  logic [31:0] ld_word_i,
  output logic [31:0] st_data_o,
  output logic [3:0]  st_strb_o,
  output logic [31:0] ld_data_o,
  output logic        err_o
);

  logic [31:0] ld_sh;
  logic [3:0]  strb_base;
  logic        mis;

  // Store lane placement and byte strobes.
  always_comb begin
    st_data_o = st_data_i << {off_i, 3'b000};
    unique case (size_i[1:0])
      2'b00:   strb_base = 4'b0001;
      2'b01:   strb_base = 4'b0011;
      default: strb_base = 4'b1111;
    endcase
    st_strb_o = strb_base << off_i;
  end

  // Load lane extraction and sign/zero extension.
  always_comb begin
    ld_sh = ld_word_i >> {off_i, 3'b000};
    unique case (size_i)
      F3_LB:   ld_data_o = {{24{ld_sh[7]}}, ld_sh[7:0]};
      F3_LH:   ld_data_o = {{16{ld_sh[15]}}, ld_sh[15:0]};
      F3_LBU:  ld_data_o = {24'd0, ld_sh[7:0]};
      F3_LHU:  ld_data_o = {16'd0, ld_sh[15:0]};
      default: ld_data_o = ld_sh;
    endcase
  end

  // Halfwords need even offsets, words need offset 0.
  always_comb begin
    mis = 1'b0;
    unique case (1'b1)
      (size_i[1:0] == 2'b01): mis = off_i[0];
      (size_i[1:0] == 2'b10): mis = (off_i != 2'b00);
      default:                mis = 1'b0;
    endcase
    err_o = mis || !size_legal(size_i, wen_i);
  end

endmodule

// File: rtl/ysyx_24100006_lsu.sv
// LSU: single-outstanding AXI-lite master for loads and stores,
// returning a one-cycle response pulse to the WBU.
module ysyx_24100006_lsu
  import ysyx_24100006_lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [2:0]        req_size,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] axi_araddr,
  output logic              axi_arvalid,
  input  logic              axi_arready,
  input  logic              axi_rvalid,
  output logic              axi_rready,
  input  logic [DATA_W-1:0] axi_rdata,
  input  logic [1:0]        axi_rresp,
  output logic [ADDR_W-1:0] axi_awaddr,
  output logic              axi_awvalid,
  input  logic              axi_awready,
  output logic [DATA_W-1:0] axi_wdata,
  output logic [7:0]        axi_wstrb,
  output logic              axi_wvalid,
  input  logic              axi_wready,
  input  logic              axi_bvalid,
  output logic              axi_bready,
  input  logic [1:0]        axi_bresp
);

  lsu_state_e        state_q, state_d;
  logic [1:0]        off_q, off_d;
  logic [2:0]        size_q, size_d;
  logic [ADDR_W-1:0] araddr_q, araddr_d;
  logic              arvalid_q, arvalid_d;
  logic              rready_q, rready_d;
  logic [ADDR_W-1:0] awaddr_q, awaddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic              awvalid_q, awvalid_d;
  logic              wvalid_q, wvalid_d;
  logic              bready_q, bready_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              idle;
  logic [1:0]        al_off;
  logic [2:0]        al_size;
  logic [31:0]       al_st_data;
  logic [3:0]        al_strb;
  logic [31:0]       al_ld_data;
  logic              al_err;
  logic              aw_done;
  logic              w_done;

  assign idle    = (state_q == S_IDLE);
  assign al_off  = idle ? req_addr[1:0] : off_q;
  assign al_size = idle ? req_size : size_q;

  ysyx_24100006_lsu_align u_align (
    .off_i     (al_off),
    .size_i    (al_size),
    .wen_i     (req_wen),
    .st_data_i (req_wdata),
    .ld_word_i (axi_rdata),
    .st_data_o (al_st_data),
    .st_strb_o (al_strb),
    .ld_data_o (al_ld_data),
    .err_o     (al_err)
  );

  assign aw_done = !awvalid_q || axi_awready;
  assign w_done  = !wvalid_q || axi_wready;

  // Next-state and next-output computation for the bus FSM.
  always_comb begin
    state_d   = state_q;
    off_d     = off_q;
    size_d    = size_q;
    araddr_d  = araddr_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          off_d   = req_addr[1:0];
          size_d  = req_size;
          rdata_d = '0;
          err_d   = 1'b0;
          if (al_err) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else if (req_wen) begin
            awaddr_d  = {req_addr[ADDR_W-1:2], 2'b00};
            wdata_d   = al_st_data;
            wstrb_d   = al_strb;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = S_WR_REQ;
          end else begin
            araddr_d  = {req_addr[ADDR_W-1:2], 2'b00};
            arvalid_d = 1'b1;
            state_d   = S_RD_ADDR;
          end
        end
      end
      S_RD_ADDR: begin
        if (axi_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = S_RD_DATA;
        end
      end
      S_RD_DATA: begin
        if (axi_rvalid) begin
          rready_d = 1'b0;
          rdata_d  = al_ld_data;
          err_d    = (axi_rresp != AXI_OKAY);
          state_d  = S_DONE;
        end
      end
      S_WR_REQ: begin
        if (awvalid_q && axi_awready) awvalid_d = 1'b0;
        if (wvalid_q && axi_wready)   wvalid_d  = 1'b0;
        if (aw_done && w_done) begin
          bready_d = 1'b1;
          state_d  = S_WR_RESP;
        end
      end
      S_WR_RESP: begin
        if (axi_bvalid) begin
          bready_d = 1'b0;
          err_d    = (axi_bresp != AXI_OKAY);
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        err_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset abandons any bus transfer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      off_q     <= '0;
      size_q    <= '0;
      araddr_q  <= '0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      off_q     <= off_d;
      size_q    <= size_d;
      araddr_q  <= araddr_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  assign req_ready   = idle;
  assign resp_valid  = (state_q == S_DONE);
  assign resp_rdata  = rdata_q;
  assign resp_err    = err_q;
  assign axi_araddr  = araddr_q;
  assign axi_arvalid = arvalid_q;
  assign axi_rready  = rready_q;
  assign axi_awaddr  = awaddr_q;
  assign axi_awvalid = awvalid_q;
  assign axi_wdata   = wdata_q;
  assign axi_wstrb   = {4'b0000, wstrb_q};
  assign axi_wvalid  = wvalid_q;
  assign axi_bready  = bready_q;

endmodule

// File: tb/tb_ysyx_24100006_lsu.sv
// Directed bench for the LSU with a delay-programmable AXI-lite slave
// and a response scoreboard.
module tb_ysyx_24100006_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_size;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] axi_araddr;
  logic        axi_arvalid;
  logic        axi_arready;
  logic        axi_rvalid;
  logic        axi_rready;
  logic [31:0] axi_rdata;
  logic [1:0]  axi_rresp;
  logic [31:0] axi_awaddr;
  logic        axi_awvalid;
  logic        axi_awready;
  logic [31:0] axi_wdata;
  logic [7:0]  axi_wstrb;
  logic        axi_wvalid;
  logic        axi_wready;
  logic        axi_bvalid;
  logic        axi_bready;
  logic [1:0]  axi_bresp;

  always #5 clk = ~clk;

  ysyx_24100006_lsu dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_wen     (req_wen),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_size    (req_size),
    .resp_valid  (resp_valid),
    .resp_rdata  (resp_rdata),
    .resp_err    (resp_err),
    .axi_araddr  (axi_araddr),
    .axi_arvalid (axi_arvalid),
    .axi_arready (axi_arready),
    .axi_rvalid  (axi_rvalid),
    .axi_rready  (axi_rready),
    .axi_rdata   (axi_rdata),
    .axi_rresp   (axi_rresp),
    .axi_awaddr  (axi_awaddr),
    .axi_awvalid (axi_awvalid),
    .axi_awready (axi_awready),
    .axi_wdata   (axi_wdata),
    .axi_wstrb   (axi_wstrb),
    .axi_wvalid  (axi_wvalid),
    .axi_wready  (axi_wready),
    .axi_bvalid  (axi_bvalid),
    .axi_bready  (axi_bready),
    .axi_bresp   (axi_bresp)
  );

  int checks = 0;
  int passes = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Slave knobs
  int          ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0;
  logic [1:0]  rresp_v = 2'b00, bresp_v = 2'b00;
  logic [31:0] mem_word = 32'h0;

  // Slave state
  int   ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
  logic r_pend, aw_got, w_got, b_pend;
  int   ar_hs = 0, aw_hs = 0, w_hs = 0, resp_cnt = 0;
  logic [31:0] cap_araddr, cap_awaddr, cap_wdata;
  logic [7:0]  cap_wstrb;

  assign axi_arready = axi_arvalid && (ar_cnt >= ar_dly);
  assign axi_awready = axi_awvalid && (aw_cnt >= aw_dly);
  assign axi_wready  = axi_wvalid && (w_cnt >= w_dly);
  assign axi_rvalid  = r_pend && (r_cnt >= r_dly);
  assign axi_bvalid  = b_pend && (b_cnt >= b_dly);
  assign axi_rdata   = axi_rvalid ? mem_word : 32'h0;
  assign axi_rresp   = axi_rvalid ? rresp_v : 2'b00;
  assign axi_bresp   = axi_bvalid ? bresp_v : 2'b00;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      ar_cnt <= 0; r_cnt <= 0; aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0;
      r_pend <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b0;
    end else begin
      ar_cnt <= (axi_arvalid && !axi_arready) ? ar_cnt + 1 : 0;
      aw_cnt <= (axi_awvalid && !axi_awready) ? aw_cnt + 1 : 0;
      w_cnt  <= (axi_wvalid && !axi_wready) ? w_cnt + 1 : 0;
      if (axi_arvalid && axi_arready) begin
        r_pend <= 1'b1; r_cnt <= 0;
        ar_hs <= ar_hs + 1; cap_araddr <= axi_araddr;
      end else if (r_pend && !axi_rvalid) r_cnt <= r_cnt + 1;
      if (axi_rvalid && axi_rready) r_pend <= 1'b0;
      if (axi_awvalid && axi_awready) begin
        aw_got <= 1'b1; aw_hs <= aw_hs + 1; cap_awaddr <= axi_awaddr;
      end
      if (axi_wvalid && axi_wready) begin
        w_got <= 1'b1; w_hs <= w_hs + 1;
        cap_wdata <= axi_wdata; cap_wstrb <= axi_wstrb;
      end
      if (aw_got && w_got && !b_pend) begin
        b_pend <= 1'b1; b_cnt <= 0; aw_got <= 1'b0; w_got <= 1'b0;
      end else if (b_pend && !axi_bvalid) b_cnt <= b_cnt + 1;
      if (axi_bvalid && axi_bready) b_pend <= 1'b0;
    end
  end

  always @(posedge clk) if (resp_valid) resp_cnt <= resp_cnt + 1;

  // Protocol monitor: valids held and payload stable until handshake.
  logic        p_arv = 0, p_arr = 0, p_awv = 0, p_awr = 0, p_wv = 0, p_wr = 0;
  logic [31:0] p_ara, p_awa, p_wd;
  logic [7:0]  p_ws;
  always @(negedge clk) begin
    if (reset) begin
      p_arv = 0; p_awv = 0; p_wv = 0;
    end else begin
      if (p_arv && !p_arr) begin
        chk("ar_hold", 32'(axi_arvalid), 32'd1);
        chk("ar_stable", axi_araddr, p_ara);
      end
      if (p_awv && !p_awr) begin
        chk("aw_hold", 32'(axi_awvalid), 32'd1);
        chk("aw_stable", axi_awaddr, p_awa);
      end
      if (p_wv && !p_wr) begin
        chk("w_hold", 32'(axi_wvalid), 32'd1);
        chk("w_stable", {axi_wstrb, axi_wdata[23:0]}, {p_ws, p_wd[23:0]});
      end
      if (axi_arvalid || axi_awvalid)
        chk("ar_aw_excl", 32'(axi_arvalid & axi_awvalid), 32'd0);
      p_arv = axi_arvalid; p_arr = axi_arready; p_ara = axi_araddr;
      p_awv = axi_awvalid; p_awr = axi_awready; p_awa = axi_awaddr;
      p_wv = axi_wvalid; p_wr = axi_wready; p_wd = axi_wdata;
      p_ws = axi_wstrb;
    end
  end

  logic [32:0] exp_q[$];

  task automatic do_req(input string tag, input logic wen,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [2:0] size, input logic [31:0] exp_rd,
                        input logic exp_err, input int exp_lat);
    int n;
    logic [32:0] e;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_wen = wen; req_addr = addr;
    req_wdata = wd; req_size = size;
    exp_q.push_back({exp_err, exp_rd});
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    n = 1;
    while (!resp_valid && n < 200) begin @(negedge clk); n++; end
    e = exp_q.pop_front();
    if (!resp_valid) begin
      chk({tag, "_resp_timeout"}, 32'd0, 32'd1);
    end else begin
      chk({tag, "_rdata"}, resp_rdata, e[31:0]);
      chk({tag, "_err"}, 32'(resp_err), 32'(e[32]));
      if (exp_lat > 0) chk({tag, "_latency"}, n, exp_lat);
    end
    @(negedge clk);
    chk({tag, "_pulse_len"}, 32'(resp_valid), 32'd0);
  endtask

  int ar0, aw0, rc0, n;

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_wen = 1'b0;
    req_addr = '0; req_wdata = '0; req_size = '0;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_arvalid", 32'(axi_arvalid), 32'd0);
    chk("rst_awvalid", 32'(axi_awvalid), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_wstrb", 32'(axi_wstrb), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    mem_word = 32'hDEADBEEF;
    do_req("lw", 1'b0, 32'h80000004, 32'h0, 3'b010, 32'hDEADBEEF, 1'b0, 0);
    chk("lw_araddr", cap_araddr, 32'h80000004);

    mem_word = 32'h80FF1234;
    do_req("lb", 1'b0, 32'h80000003, 32'h0, 3'b000, 32'hFFFFFF80, 1'b0, 0);
    chk("lb_araddr", cap_araddr, 32'h80000000);
    do_req("lbu", 1'b0, 32'h80000003, 32'h0, 3'b100, 32'h00000080, 1'b0, 0);
    do_req("lh", 1'b0, 32'h80000002, 32'h0, 3'b001, 32'hFFFF80FF, 1'b0, 0);

    do_req("sb", 1'b1, 32'h80000001, 32'h000000AB, 3'b000, 32'h0, 1'b0, 0);
    chk("sb_awaddr", cap_awaddr, 32'h80000000);
    chk("sb_wdata", cap_wdata, 32'h0000AB00);
    chk("sb_wstrb", 32'(cap_wstrb), 32'h02);
    do_req("sh", 1'b1, 32'h80000002, 32'h00001234, 3'b001, 32'h0, 1'b0, 0);
    chk("sh_wdata", cap_wdata, 32'h12340000);
    chk("sh_wstrb", 32'(cap_wstrb), 32'h0C);

    ar0 = ar_hs; aw0 = aw_hs;
    do_req("mis_lw", 1'b0, 32'h80000002, 32'h0, 3'b010, 32'h0, 1'b1, 1);
    do_req("mis_sh", 1'b1, 32'h80000003, 32'h5555, 3'b001, 32'h0, 1'b1, 1);
    do_req("ill_ld", 1'b0, 32'h80000000, 32'h0, 3'b011, 32'h0, 1'b1, 1);
    do_req("ill_st", 1'b1, 32'h80000000, 32'h77, 3'b100, 32'h0, 1'b1, 1);
    chk("rej_no_ar", ar_hs, ar0);
    chk("rej_no_aw", aw_hs, aw0);

    ar_dly = 3; r_dly = 5; rc0 = resp_cnt;
    do_req("lhu_stall", 1'b0, 32'h80000002, 32'h0, 3'b101,
           32'h000080FF, 1'b0, 0);
    chk("lhu_stall_one_resp", resp_cnt - rc0, 1);

    ar_dly = 0; r_dly = 1; aw_dly = 1; w_dly = 4; b_dly = 2;
    rc0 = resp_cnt;
    do_req("sw_stall", 1'b1, 32'h80000008, 32'hCAFEF00D, 3'b010,
           32'h0, 1'b0, 0);
    chk("sw_stall_one_resp", resp_cnt - rc0, 1);
    chk("sw_awaddr", cap_awaddr, 32'h80000008);
    chk("sw_wdata", cap_wdata, 32'hCAFEF00D);
    chk("sw_wstrb", 32'(cap_wstrb), 32'h0F);
    aw_dly = 4; w_dly = 0;
    do_req("sb_stall", 1'b1, 32'h80000003, 32'h000000C3, 3'b000,
           32'h0, 1'b0, 0);
    chk("sb3_wdata", cap_wdata, 32'hC3000000);
    chk("sb3_wstrb", 32'(cap_wstrb), 32'h08);

    mem_word = 32'hDEADBEEF; rresp_v = 2'b10;
    do_req("lw_slverr", 1'b0, 32'h80000004, 32'h0, 3'b010,
           32'hDEADBEEF, 1'b1, 0);
    rresp_v = 2'b00; bresp_v = 2'b10;
    do_req("sw_slverr", 1'b1, 32'h80000004, 32'h1, 3'b010, 32'h0, 1'b1, 0);
    bresp_v = 2'b00;

    // Async reset while waiting for read data.
    ar_dly = 0; r_dly = 30; aw_dly = 0; b_dly = 0;
    req_valid = 1'b1; req_wen = 1'b0; req_addr = 32'h80000010;
    req_size = 3'b010;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (!axi_rready && n < 20) begin @(negedge clk); n++; end
    chk("rstmid_in_rdata", 32'(axi_rready), 32'd1);
    rc0 = resp_cnt;
    #2 reset = 1'b1;
    #1;
    chk("rstmid_arvalid", 32'(axi_arvalid), 32'd0);
    chk("rstmid_rready", 32'(axi_rready), 32'd0);
    chk("rstmid_awvalid", 32'(axi_awvalid), 32'd0);
    chk("rstmid_wvalid", 32'(axi_wvalid), 32'd0);
    chk("rstmid_bready", 32'(axi_bready), 32'd0);
    chk("rstmid_resp_valid", 32'(resp_valid), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rstmid_req_ready", 32'(req_ready), 32'd1);
    chk("rstmid_no_resp", resp_cnt, rc0);
    r_dly = 0;

    mem_word = 32'h0BADF00D;
    do_req("lw_after_rst", 1'b0, 32'h8000000C, 32'h0, 3'b010,
           32'h0BADF00D, 1'b0, 0);
    chk("lw_after_rst_araddr", cap_araddr, 32'h8000000C);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/ysyx_24100006_lsu.md
Name: ysyx_24100006_lsu

Overview:
Load/store unit bus master that sits directly upstream of the DPI-backed AXI-lite data memory slave. It accepts one load or store request at a time from the EXU and aligns store data and byte strobes. It then drives the AXI-lite AR/R or AW/W/B channels, and returns a sign- or zero-extended load result, or a store completion, to the WBU as a one-cycle response pulse. Misaligned or illegal-size accesses are rejected locally and never reach the bus.

Parameters:
ADDR_W, 32, address width.
DATA_W, 32, data width; only 32 is supported.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
req_valid  in  1  CPU request valid
req_ready  out  1  LSU can accept a request (high only in IDLE)
req_wen  in  1  1 = store, 0 = load
req_addr  in  32  byte address
req_wdata  in  32  store data (LSB-justified)
req_size  in  3  RISC-V funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU)
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  32  extended load data; 0 for stores
resp_err  out  1  misaligned, illegal size, or bus error
axi_araddr  out  32  word-aligned read address
axi_arvalid  out  1  read address valid
axi_arready  in  1  read address ready
axi_rvalid  in  1  read data valid
axi_rready  out  1  read data ready
axi_rdata  in  32  read data
axi_rresp  in  2  read response (00 = OKAY)
axi_awaddr  out  32  word-aligned write address
axi_awvalid  out  1  write address valid
axi_awready  in  1  write address ready
axi_wdata  out  32  lane-shifted store data
axi_wstrb  out  8  byte strobes; [7:4] are always 0
axi_wvalid  out  1  write data valid
axi_wready  in  1  write data ready
axi_bvalid  in  1  write response valid
axi_bready  out  1  write response ready
axi_bresp  in  2  write response (00 = OKAY)

Behaviour:
- Reset (async, active-high): state=IDLE. All valid/ready outputs and resp_err are 0; resp_rdata=0; axi_* address, data and strobe registers are 0. Any outstanding transaction is abandoned.
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE.
- IDLE: req_ready=1. On req_valid, latch addr, wdata, size, wen and offset = addr[1:0].
  - Illegal size (011/110/111, or 100/101 with wen=1), H at offset 01 or 11, or W at offset != 00: go to DONE with resp_err=1; no AXI activity.
  - Load: axi_araddr={addr[31:2],2'b00}; arvalid=1; go to RD_ADDR.
  - Store: axi_awaddr aligned the same way; wdata=wdata<<(8*offset); wstrb = 0001/0011/1111 << offset; awvalid=wvalid=1; go to WR_REQ.
- RD_ADDR: hold arvalid and araddr stable until arready. On the handshake, arvalid=0, rready=1, go to RD_DATA.
- RD_DATA: on rvalid&&rready, rready=0. Extract the byte or halfword at offset, then sign-extend (000/001) or zero-extend (100/101) into resp_rdata. resp_err=(rresp!=00). Go to DONE.
- WR_REQ: awvalid and wvalid drop independently on their own handshakes. Both may complete in the same cycle. When both have completed, bready=1 and go to WR_RESP.
- WR_RESP: on bvalid&&bready, bready=0, resp_err=(bresp!=00), go to DONE.
- DONE: resp_valid=1 for exactly one cycle. Next state is IDLE; resp_err clears on leaving DONE.
- Back-to-back requests: req_ready is low in DONE, so the minimum request spacing is one idle-to-idle round trip.
- AXI valids never deassert before their handshake; address, data and strobe stay stable while valid is high.
- arvalid and awvalid are never both high.

Decomposition:
- Package ysyx_24100006_lsu_pkg holds: state encoding; funct3 constants (LB, LH, LW, LBU, LHU, SB, SH, SW); AXI resp codes (OKAY=2'b00, SLVERR=2'b10).
- One combinational sub-module, ysyx_24100006_lsu_align:
  - store side: shifts wdata and generates wstrb;
  - load side: extracts and extends read data;
  - misalignment/illegal-size check.
- The FSM stays in the top module.

Test Plan:
- LW addr 0x80000004, memory word 0xDEADBEEF, zero-wait slave -> araddr 0x80000004; one resp_valid pulse with rdata 0xDEADBEEF, err 0.
- LB addr 0x80000003 on word 0x80FF1234 -> araddr 0x80000000; rdata 0xFFFFFF80. LBU same -> 0x00000080. LH addr 0x80000002 on word 0x80FF1234 -> 0xFFFF80FF.
- SB addr 0x80000001, wdata 0x000000AB -> awaddr 0x80000000, wdata 0x0000AB00, wstrb 0x02. SH addr 0x80000002, wdata 0x1234 -> wdata 0x12340000, wstrb 0x0C. After bvalid, resp_valid with err 0.
- Misaligned LW at 0x80000002 and SH at 0x80000003 -> no arvalid/awvalid; resp_valid with err=1 one cycle after acceptance.
- Slave stalls: arready delayed 3 cycles, rvalid delayed 5 cycles, awready and wready arriving in different cycles -> valids held stable throughout, exactly one resp_valid. rresp=2'b10 -> err=1.
- Reset asserted asynchronously mid-RD_DATA -> all valids 0 immediately, state IDLE, req_ready=1 after reset release, no spurious resp_valid.
